// File: rtl/key_expansion_if.sv
// Purpose : handshake and key bus between the AES-128 key-schedule engine and
//           the logic that requests expansions and consumes the round keys.
// Signals : start        - request a new expansion of key_in
//           key_in       - 128-bit cipher key, byte 0 in [127:120]
//           expanded_key - w[0]..w[43], w[i] at [1407-32*i -: 32]
//           busy         - expansion in progress
//           finish       - expanded_key is complete and valid
interface key_expansion_if;
  logic          start;
  logic [127:0]  key_in;
  logic [1407:0] expanded_key;
  logic          busy;
  logic          finish;

  modport master (output start, key_in, input expanded_key, busy, finish);
  modport slave  (input start, key_in, output expanded_key, busy, finish);
endinterface

// File: rtl/key_expansion.sv
// Purpose : iterative AES-128 key schedule. One 32-bit word per clock, so 40
//           cycles from the accepting edge to a complete 1408-bit expanded key.
//           Round key r sits at expanded_key[1407-128*r -: 128].
// Ports   : clk - rising-edge clock
//           rst - asynchronous, active-low reset
//           bus - key_expansion_if.slave (start, key_in, expanded_key, busy, finish)
//
// state    | meaning
// S_IDLE   | no key yet, outputs zero, waiting for start
// S_EXPAND | writing w[4]..w[43], one word per cycle
// S_DONE   | expanded_key valid and held, start restarts
module key_expansion #(
  parameter int NR = 10
) (
  input  logic           clk,
  input  logic           rst,
  key_expansion_if.slave bus
);
  localparam int NW    = 4 * (NR + 1);
  localparam int EXP_W = 32 * NW;

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_w [0:NW-1];
  logic [5:0]  r_i;
  logic [7:0]  r_rcon;
  logic        r_busy, r_finish;

  logic [31:0]      w_prev, w_rot, w_sub, w_temp, w_new;
  logic [EXP_W-1:0] w_exp;
  logic             w_accept;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box computed rather than tabulated: multiplicative inverse as x^254
  // (product of x^2, x^4, ..., x^128; maps 0 to 0), then the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] t, r;
    t = gf_mul(x, x);
    r = t;
    for (int k = 2; k < 8; k++) begin
      t = gf_mul(t, t);
      r = gf_mul(r, t);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
             ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  assign w_accept = bus.start && (r_state != S_EXPAND);

  assign w_prev = r_w[r_i - 6'd1];
  assign w_rot  = {w_prev[23:0], w_prev[31:24]};
  assign w_sub  = {sbox(w_rot[31:24]), sbox(w_rot[23:16]),
                   sbox(w_rot[15:8]),  sbox(w_rot[7:0])};
  assign w_temp = (r_i[1:0] == 2'b00) ? (w_sub ^ {r_rcon, 24'h0}) : w_prev;
  assign w_new  = r_w[r_i - 6'd4] ^ w_temp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE,
      S_DONE:   if (bus.start) w_state_nxt = S_EXPAND;
      S_EXPAND: if (r_i == 6'(NW - 1)) w_state_nxt = S_DONE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NW; k++) r_w[k] <= 32'h0;
      r_i      <= 6'd0;
      r_rcon   <= 8'h01;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
    end else if (w_accept) begin
      for (int k = 0; k < NW; k++) r_w[k] <= 32'h0;
      r_w[0]   <= bus.key_in[127:96];
      r_w[1]   <= bus.key_in[95:64];
      r_w[2]   <= bus.key_in[63:32];
      r_w[3]   <= bus.key_in[31:0];
      r_i      <= 6'd4;
      r_rcon   <= 8'h01;
      r_busy   <= 1'b1;
      r_finish <= 1'b0;
    end else if (r_state == S_EXPAND) begin
      r_w[r_i] <= w_new;
      r_i      <= r_i + 6'd1;
      if (r_i[1:0] == 2'b00) r_rcon <= xtime(r_rcon);
      if (r_i == 6'(NW - 1)) begin
        r_busy   <= 1'b0;
        r_finish <= 1'b1;
      end
    end
  end

  always_comb begin
    w_exp = '0;
    for (int k = 0; k < NW; k++) w_exp[EXP_W-1-32*k -: 32] = r_w[k];
  end

  assign bus.expanded_key = w_exp;
  assign bus.busy         = r_busy;
  assign bus.finish       = r_finish;
endmodule

// File: tb/tb_key_expansion.sv
module tb_key_expansion;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   tests = 0;
  int   errors = 0;

  key_expansion_if bus();

  key_expansion #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] K2 = 128'h65787061_6E642033_322D6279_7465206B;
  localparam logic [127:0] K3 = 128'h2B7E1516_28AED2A6_ABF71588_09CF4F3C;

  typedef struct {
    string        name;
    logic [127:0] key;
    int           idx;
    logic [31:0]  exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word(input int idx);
    return bus.expanded_key[1407-32*idx -: 32];
  endfunction

  function automatic logic [127:0] rkey(input int r);
    return bus.expanded_key[1407-128*r -: 128];
  endfunction

  // Accepting edge is the posedge between the two negedges below; cyc counts
  // posedges after it, so finish first seen at cyc==40 means E+40.
  task automatic run_key(input logic [127:0] k, input bit inject,
                         output int cyc, output logic b0, output logic f0);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = k;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.key_in = ~k;
    b0  = bus.busy;
    f0  = bus.finish;
    cyc = 0;
    while (!bus.finish && cyc < 100) begin
      if (inject && (cyc == 5 || cyc == 20)) begin
        bus.start  = 1'b1;
        bus.key_in = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int   cyc;
    logic b0, f0;
    logic [127:0] rk10_k2, st;

    vecs.push_back('{"k3_w0",  K3, 0,  32'h2B7E1516});
    vecs.push_back('{"k3_w3",  K3, 3,  32'h09CF4F3C});
    vecs.push_back('{"k3_w4",  K3, 4,  32'hA0FAFE17});
    vecs.push_back('{"k3_w5",  K3, 5,  32'h88542CB1});
    vecs.push_back('{"k3_w6",  K3, 6,  32'h23A33939});
    vecs.push_back('{"k3_w7",  K3, 7,  32'h2A6C7605});
    vecs.push_back('{"k3_w8",  K3, 8,  32'hF2C295F2});
    vecs.push_back('{"k3_w40", K3, 40, 32'hD014F9A8});
    vecs.push_back('{"k3_w43", K3, 43, 32'hB6630CA6});
    vecs.push_back('{"k2_w0",  K2, 0,  32'h65787061});
    vecs.push_back('{"k2_w4",  K2, 4,  32'h29CF0FF3});
    vecs.push_back('{"k2_w41", K2, 41, 32'hF13D5661});
    vecs.push_back('{"k2_w43", K2, 43, 32'h15280270});

    rk10_k2 = 128'h782A7509_F13D5661_2EA71A58_15280270;
    st      = 128'h00010203_04050607_08090A0B_0C0D0E0F;

    bus.start  = 1'b0;
    bus.key_in = K2;

    // held in reset while start toggles
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.start = ~bus.start;
      #1;
      check("reset_hold", {bus.expanded_key == '0, bus.busy, bus.finish}, {1'b1, 1'b0, 1'b0});
    end
    @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {bus.busy, bus.finish}, 2'b00);

    // table vectors
    foreach (vecs[n]) begin
      run_key(vecs[n].key, 1'b0, cyc, b0, f0);
      check({vecs[n].name, "_lat"}, cyc, 40);
      check(vecs[n].name, word(vecs[n].idx), vecs[n].exp);
    end

    // main key: latency, round 10, round-key-5 addroundkey result, hold in DONE
    run_key(K2, 1'b0, cyc, b0, f0);
    check("k2_busy_after_start", {b0, f0}, 2'b10);
    check("k2_latency", cyc, 40);
    check("k2_round10", rkey(10), rk10_k2);
    check("k2_ark_r5", rkey(5) ^ st, 128'h37F90453_1837E855_5351CD6C_75A2944E);
    repeat (10) @(negedge clk);
    check("done_hold", {bus.finish, bus.busy, rkey(10)}, {1'b1, 1'b0, rk10_k2});

    // start pulses mid-expansion with a different key are ignored
    run_key(K2, 1'b1, cyc, b0, f0);
    check("ignore_start_latency", cyc, 40);
    check("ignore_start_round10", rkey(10), rk10_k2);
    check("ignore_start_w4", word(4), 32'h29CF0FF3);

    // reset mid-expansion aborts at once
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = K3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_outputs", {bus.expanded_key == '0, bus.busy, bus.finish}, {1'b1, 1'b0, 1'b0});
    @(negedge clk);
    rst = 1'b1;
    run_key(K3, 1'b0, cyc, b0, f0);
    check("after_abort_latency", cyc, 40);
    check("after_abort_w4", word(4), 32'hA0FAFE17);
    check("after_abort_w43", word(43), 32'hB6630CA6);

    // restart from DONE
    run_key(K2, 1'b0, cyc, b0, f0);
    check("restart_flags", {b0, f0}, 2'b10);
    check("restart_latency", cyc, 40);
    check("restart_round10", rkey(10), rk10_k2);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
